// File: rtl/lc3b_mem_arbiter_if.sv
// Bundle of fetch-client, data-client and physical-memory signals around the LC-3b memory arbiter.
// The slave modport is the arbiter's view; the master modport is the clients' and memory's view.
interface lc3b_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [DATA_W-1:0] i_rdata;

  logic              d_read;
  logic              d_write;
  logic [1:0]        d_byte_enable;
  logic [ADDR_W-1:0] d_address;
  logic [DATA_W-1:0] d_wdata;
  logic              d_resp;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_byte_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  logic              arb_timeout;

  modport slave (
    input  i_read, i_address,
    input  d_read, d_write, d_byte_enable, d_address, d_wdata,
    input  mem_resp, mem_rdata,
    output i_resp, i_rdata, d_resp, d_rdata,
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output arb_timeout
  );

  modport master (
    output i_read, i_address,
    output d_read, d_write, d_byte_enable, d_address, d_wdata,
    output mem_resp, mem_rdata,
    input  i_resp, i_rdata, d_resp, d_rdata,
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  arb_timeout
  );
endinterface

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one LC-3b memory port between fetch and data clients.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN (TIMEOUT_CYCLES then sets the abort point).
module lc3b_mem_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
`ifdef ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lc3b_mem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   last_grant_d;   // 1: data client won the previous grant
  logic   d_req;
  logic   grant_i;
  logic   grant_d;
  logic   timeout_hit;
  logic   done;

  assign d_req   = bus.d_read | bus.d_write;
  // On a tie the client that did not win last time is granted.
  assign grant_i = bus.i_read & (~d_req | last_grant_d);
  assign grant_d = d_req & (~bus.i_read | ~last_grant_d);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state_q == IDLE) cnt_q <= '0;
    else                           cnt_q <= cnt_q + CNT_W'(1);
  end

  // A completion arriving in the final cycle takes priority over the abort.
  assign timeout_hit = (state_q != IDLE) & ~bus.mem_resp &
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = bus.mem_resp | timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_i)      state_d = BUSY_I;
        else if (grant_d) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Responses are combinational so the owner sees completion in the mem_resp cycle.
  always_comb begin
    bus.i_resp      = 1'b0;
    bus.i_rdata     = DATA_W'(0);
    bus.d_resp      = 1'b0;
    bus.d_rdata     = DATA_W'(0);
    bus.arb_timeout = 1'b0;
    if (rst_n) begin
      case (state_q)
        BUSY_I: begin
          bus.i_resp = done;
          if (bus.mem_resp) bus.i_rdata = bus.mem_rdata;
        end
        BUSY_D: begin
          bus.d_resp = done;
          if (bus.mem_resp) bus.d_rdata = bus.mem_rdata;
        end
        default: ;
      endcase
      bus.arb_timeout = timeout_hit;
    end
  end

  // Memory command is latched at grant and held until the transaction ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_read        <= 1'b0;
      bus.mem_write       <= 1'b0;
      bus.mem_byte_enable <= 2'b00;
      bus.mem_address     <= ADDR_W'(0);
      bus.mem_wdata       <= DATA_W'(0);
      last_grant_d        <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_i) begin
            bus.mem_read        <= 1'b1;
            bus.mem_write       <= 1'b0;
            bus.mem_byte_enable <= 2'b11;
            bus.mem_address     <= bus.i_address;
            bus.mem_wdata       <= DATA_W'(0);
            last_grant_d        <= 1'b0;
          end else if (grant_d) begin
            bus.mem_read        <= ~bus.d_write;
            bus.mem_write       <= bus.d_write;
            bus.mem_byte_enable <= bus.d_write ? bus.d_byte_enable : 2'b11;
            bus.mem_address     <= bus.d_address;
            bus.mem_wdata       <= bus.d_wdata;
            last_grant_d        <= 1'b1;
          end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
          end
        end
        default: begin
          if (done) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
